// File: rtl/ex_div_seq_pkg.sv
// Shared types and helpers for the EX-stage iterative divider.
// Holds XLEN, the funct3 codes of the RV64M divide group and the sequencer states.
package ex_div_seq_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // W forms always deliver a sign-extended 32-bit result, unsigned ones included.
  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic word);
    return word ? sext32(v[31:0]) : v;
  endfunction

endpackage

// File: rtl/ex_div_seq.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU (+W): N+1 cycles to result (N=64/32), 1 for /0 and MIN/-1.
// Stalls EX while iterating, then holds out_valid_o/result_o until result_ready_i; flush_i aborts at any point.
module ex_div_seq
  import ex_div_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid_i,
  input  logic            flush_i,
  input  logic [2:0]      fun3_i,
  input  logic            is_word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            result_ready_i,
  output logic            stall_o,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_o
);

  div_state_t      state;
  logic [5:0]      cnt;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] dvs;
  logic            neg_q;
  logic            neg_r;
  logic            is_rem;
  logic            is_word;

  logic            op_signed;
  logic            op_rem;
  logic [XLEN-1:0] a_val;
  logic [XLEN-1:0] b_val;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] spec_res;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            overflow;

  logic [XLEN+1:0] rem_sh;
  logic [XLEN+1:0] diff;
  logic            take;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quot_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin_res;

  assign stall_o = div_valid_i & ~out_valid_o & ~flush_i;

  // Operand decode: W forms see only the low word, widened according to signedness.
  always_comb begin
    op_signed = (fun3_i == F3_DIV) || (fun3_i == F3_REM);
    op_rem    = (fun3_i == F3_REM) || (fun3_i == F3_REMU);
    if (is_word_i) begin
      a_val = op_signed ? sext32(src1_i[31:0]) : {32'b0, src1_i[31:0]};
      b_val = op_signed ? sext32(src2_i[31:0]) : {32'b0, src2_i[31:0]};
    end else begin
      a_val = src1_i;
      b_val = src2_i;
    end
    min_val  = is_word_i ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    a_neg    = op_signed & a_val[XLEN-1];
    b_neg    = op_signed & b_val[XLEN-1];
    a_abs    = a_neg ? -a_val : a_val;
    b_abs    = b_neg ? -b_val : b_val;
    div_zero = (b_val == '0);
    overflow = op_signed && (a_val == min_val) && (b_val == '1);
    spec_res = '0;
    if (div_zero) begin
      spec_res = op_rem ? fit(a_val, is_word_i) : '1;
    end else if (overflow) begin
      spec_res = op_rem ? '0 : min_val;
    end
  end

  // One shift-subtract step; the extra top bit of diff carries the borrow.
  always_comb begin
    rem_sh  = {rem, quot[XLEN-1]};
    diff    = rem_sh - {2'b00, dvs};
    take    = ~diff[XLEN+1];
    rem_nx  = take ? diff[XLEN:0] : rem_sh[XLEN:0];
    quot_nx = {quot[XLEN-2:0], take};
    q_fix   = neg_q ? -quot_nx : quot_nx;
    r_fix   = neg_r ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
    fin_res = fit(is_rem ? r_fix : q_fix, is_word);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rem         <= '0;
      quot        <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      is_rem      <= 1'b0;
      is_word     <= 1'b0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
    end else if (flush_i) begin
      state       <= ST_IDLE;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_valid_i) begin
            if (div_zero || overflow) begin
              result_o    <= spec_res;
              out_valid_o <= 1'b1;
              state       <= ST_DONE;
            end else begin
              // W dividends are parked in the upper half so the MSB-first shift works unchanged.
              quot    <= is_word_i ? {a_abs[31:0], 32'b0} : a_abs;
              dvs     <= b_abs;
              rem     <= '0;
              cnt     <= is_word_i ? 6'd31 : 6'd63;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              is_rem  <= op_rem;
              is_word <= is_word_i;
              state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          cnt  <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            result_o    <= fin_res;
            out_valid_o <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (result_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: latency, stall, special cases, hold, flush and reset abort.
module tb_ex_div_seq;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_valid_i;
  logic        flush_i;
  logic [2:0]  fun3_i;
  logic        is_word_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic        result_ready_i;
  logic        stall_o;
  logic        out_valid_o;
  logic [63:0] result_o;

  int checks = 0;
  int errors = 0;

  ex_div_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .div_valid_i    (div_valid_i),
    .flush_i        (flush_i),
    .fun3_i         (fun3_i),
    .is_word_i      (is_word_i),
    .src1_i         (src1_i),
    .src2_i         (src2_i),
    .result_ready_i (result_ready_i),
    .stall_o        (stall_o),
    .out_valid_o    (out_valid_o),
    .result_o       (result_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues an op in the current cycle T; result expected in cycle T+lat, held for 'hold' cycles.
  task automatic run_op(input string name, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat, input int hold);
    int bad;
    div_valid_i    = 1'b1;
    fun3_i         = f3;
    is_word_i      = w;
    src1_i         = a;
    src2_i         = b;
    result_ready_i = 1'b0;
    flush_i        = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b1 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: stall=%b valid=%b, required stall=1 valid=0", name, stall_o, out_valid_o);
    end
    bad = 0;
    for (int k = 1; k < lat; k++) begin
      step();
      if (stall_o !== 1'b1 || out_valid_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s busy: %0d cycles with stall!=1 or valid!=0, required 0", name, bad);
    end
    step();
    checks++;
    if (out_valid_o !== 1'b1 || result_o !== exp || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL %s result@T+%0d: valid=%b stall=%b result=%h, required valid=1 stall=0 result=%h",
               name, lat, out_valid_o, stall_o, result_o, exp);
    end
    for (int h = 0; h < hold; h++) begin
      step();
      checks++;
      if (out_valid_o !== 1'b1 || result_o !== exp || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b stall=%b result=%h, required valid=1 stall=0 result=%h",
                 name, h, out_valid_o, stall_o, result_o, exp);
      end
    end
    result_ready_i = 1'b1;
    step();
    div_valid_i    = 1'b0;
    result_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s release: valid=%b, required 0", name, out_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (out_valid_o !== 1'b0 || result_o !== 64'h0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b result=%h stall=%b, required 0/0/0", out_valid_o, result_o, stall_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_div64();
    run_op("div_m20_3",  DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 0);
    run_op("rem_m20_3",  REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("div_20_m3",  DIV,  1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 65, 0);
    run_op("remu_100_7", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65, 0);
  endtask

  task automatic test_word();
    run_op("divw_min_2",   DIV,  1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33, 0);
    run_op("divuw_fffe_2", DIVU, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 0);
    run_op("remuw_7_4",    REMU, 1'b1, 64'h0000_0001_0000_0007, 64'hFFFF_FFFF_0000_0004, 64'd3, 33, 0);
  endtask

  task automatic test_div_zero();
    run_op("divu_5_0",   DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem_5_0",    REM,  1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("remuw_x_0",  REMU, 1'b1, 64'h0000_0000_8000_0001, 64'hAAAA_AAAA_0000_0000,
           64'hFFFF_FFFF_8000_0001, 1, 0);
  endtask

  task automatic test_overflow();
    run_op("div_min_m1",  DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_min_m1",  REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run_op("divw_min_m1", DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0);
  endtask

  task automatic test_hold();
    run_op("div_100_7_hold", DIV, 1'b0, 64'd100, 64'd7, 64'd14, 65, 3);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_divu_9_2", DIVU, 1'b0, 64'd9, 64'd2, 64'd4, 65, 0);
    run_op("b2b_remu_9_0", REMU, 1'b0, 64'd9, 64'd0, 64'd9, 1, 0);
    run_op("b2b_remw_m7_2", REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
  endtask

  task automatic test_flush();
    int bad;
    div_valid_i = 1'b1;
    fun3_i      = DIVU;
    is_word_i   = 1'b0;
    src1_i      = 64'd1000;
    src2_i      = 64'd3;
    #1;
    for (int k = 1; k <= 10; k++) step();
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall=%b, required 0", stall_o);
    end
    step();
    flush_i     = 1'b0;
    div_valid_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid_o !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_busy: %0d cycles with valid=1, required 0", bad);
    end
    // Flush in the accept cycle must win over the accept.
    div_valid_i = 1'b1;
    fun3_i      = DIVU;
    src1_i      = 64'd5;
    src2_i      = 64'd0;
    flush_i     = 1'b1;
    step();
    flush_i     = 1'b0;
    div_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: valid=%b, required 0", out_valid_o);
    end
    step();
    run_op("after_flush", DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
  endtask

  task automatic test_reset_mid();
    div_valid_i = 1'b1;
    fun3_i      = DIV;
    is_word_i   = 1'b0;
    src1_i      = 64'd100;
    src2_i      = 64'd7;
    #1;
    for (int k = 0; k < 20; k++) step();
    rst_n = 1'b0;
    step();
    div_valid_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || result_o !== 64'h0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b result=%h stall=%b, required 0/0/0", out_valid_o, result_o, stall_o);
    end
    rst_n = 1'b1;
    step();
    bad_free_wait();
    run_op("after_reset", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
  endtask

  // Idle cycles after a mid-op reset must never show a stale result.
  task automatic bad_free_wait();
    int bad;
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      if (out_valid_o !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d cycles with valid=1, required 0", bad);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    div_valid_i    = 1'b0;
    flush_i        = 1'b0;
    fun3_i         = DIV;
    is_word_i      = 1'b0;
    src1_i         = '0;
    src2_i         = '0;
    result_ready_i = 1'b0;
    test_reset();
    test_div64();
    test_word();
    test_div_zero();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
